// File: rtl/fifo_stream_reader.sv
// Read-side master for the team FIFO: pops words into a two-entry skid buffer and
// presents them as a valid/ready stream with a per-packet last flag.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  fifo_rden_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  busy_o
);

    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            cnt;
    logic [DATA_WIDTH-1:0] skid0;
    logic [DATA_WIDTH-1:0] skid1;
    logic [CW-1:0]         pop_cnt;
    logic [CW-1:0]         out_cnt;
    logic                  pop;
    logic                  xfer;

    // Pop decision uses only registered occupancy, so m_ready_i never reaches fifo_rden_o.
    always_comb begin
        pop  = !flush_i && !fifo_empty_i && (cnt < 2'd2) && (state != IDLE);
        xfer = (cnt != 2'd0) && m_ready_i && !flush_i;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en_i) state_nxt = RUN;
            RUN:  if (!en_i) state_nxt = (pop_cnt != '0) ? STOP : IDLE;
            STOP: begin
                if (en_i)
                    state_nxt = RUN;
                else if (pop && (pop_cnt == LAST_BEAT))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_i)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // skid0 is always the head; a simultaneous pop and transfer at cnt==1 refills the head directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 2'd0;
            skid0 <= '0;
            skid1 <= '0;
        end else if (flush_i) begin
            cnt <= 2'd0;
        end else begin
            case ({pop, xfer})
                2'b10: begin
                    if (cnt == 2'd0)
                        skid0 <= fifo_rdata_i;
                    else
                        skid1 <= fifo_rdata_i;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    skid0 <= skid1;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: skid0 <= fifo_rdata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_cnt <= '0;
            out_cnt <= '0;
        end else if (flush_i) begin
            pop_cnt <= '0;
            out_cnt <= '0;
        end else begin
            if (pop)
                pop_cnt <= (pop_cnt == LAST_BEAT) ? '0 : pop_cnt + 1'b1;
            if (xfer)
                out_cnt <= (out_cnt == LAST_BEAT) ? '0 : out_cnt + 1'b1;
        end
    end

    always_comb begin
        fifo_rden_o = pop;
        m_valid_o   = (cnt != 2'd0);
        m_data_o    = skid0;
        m_last_o    = m_valid_o && (out_cnt == LAST_BEAT);
        busy_o      = (state != IDLE) || (cnt != 2'd0);
    end

endmodule
